alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU.
- Width is generic. Flags (carry, zero, parity, negative) are registered so they persist between instructions for branch evaluation. Carry chains into ADC.
- Multi-bit shifts run one bit per cycle. Multiply is shift-add, W cycles. All ops use a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux; the controller stalls the PC while busy=1.

---
 rtl/alu_mc.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : parametrised multi-cycle ALU with persistent flags.
//
// Single-cycle ops (ADD/ADC/SUB/AND/OR/XOR/NOT/MOV/CMP, illegal) complete on the
// edge that samples start. Shifts move one bit per cycle. MUL is a shift-add
// multiplier taking W cycles. Results and flags are written only on completion,
// so partial values never reach the outputs.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while busy=0
//   op       opcode (OPW bits), latched with start
//   a, b     operands (b also supplies the shift amount), latched with start
//   rslt     result (low half for MUL)
//   rslt_hi  MUL upper half, 0 after any other completion
//   flag_c   carry / no-borrow / last bit shifted out / MUL high half non-zero
//   flag_z   zero flag of the flag-source value
//   flag_p   reduction XOR of the flag-source value
//   flag_n   MSB of the flag-source value
//   busy     multi-cycle op in progress
//   done     one-cycle completion pulse
//   err      illegal opcode, qualified by done
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int W   = 8,
   parameter int OPW = 4,
   parameter int SHW = $clog2(W) + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   rslt,
   output logic [W-1:0]   rslt_hi,
   output logic           flag_c,
   output logic           flag_z,
   output logic           flag_p,
   output logic           flag_n,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_ADC = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB = OPW'(2);
   localparam logic [OPW-1:0] OP_AND = OPW'(3);
   localparam logic [OPW-1:0] OP_OR  = OPW'(4);
   localparam logic [OPW-1:0] OP_XOR = OPW'(5);
   localparam logic [OPW-1:0] OP_NOT = OPW'(6);
   localparam logic [OPW-1:0] OP_MOV = OPW'(7);
   localparam logic [OPW-1:0] OP_CMP = OPW'(8);
   localparam logic [OPW-1:0] OP_SHL = OPW'(9);
   localparam logic [OPW-1:0] OP_SHR = OPW'(10);
   localparam logic [OPW-1:0] OP_MUL = OPW'(11);

   localparam logic [SHW-1:0] K_MAX = SHW'(W);
   localparam logic [SHW-1:0] K_ONE = SHW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_MUL   = 2'd2
   } state_t;

   // {zero, parity, negative} of the value a completion writes
   function automatic logic [2:0] f_zpn(input logic [W-1:0] v);
      return {(v == '0), ^v, v[W-1]};
   endfunction

   state_t         r_state;
   logic [SHW-1:0] r_cnt;
   logic           r_dir;
   logic [W-1:0]   r_acc;
   logic [W-1:0]   r_phi;
   logic [W-1:0]   r_mcand;
   logic [W-1:0]   r_rslt;
   logic [W-1:0]   r_rslt_hi;
   logic           r_flag_c;
   logic           r_flag_z;
   logic           r_flag_p;
   logic           r_flag_n;
   logic           r_busy;
   logic           r_done;
   logic           r_err;

   logic [SHW-1:0] w_k;
   logic [SHW-1:0] w_steps;
   logic [W:0]     w_sum;
   logic [W:0]     w_adc;
   logic [W:0]     w_diff;
   logic [W-1:0]   w_shl1;
   logic [W-1:0]   w_shr1;
   logic [W:0]     w_m0;
   logic           w_fin;
   logic           w_ill;
   logic           w_wr;
   logic           w_go_sh;
   logic [W-1:0]   w_res;
   logic [W-1:0]   w_src;
   logic           w_c;
   logic [W-1:0]   w_sh_nxt;
   logic           w_sh_out;
   logic [W:0]     w_madd;
   logic [W-1:0]   w_mhi;
   logic [W-1:0]   w_mlo;

   // Decode of the request presented in IDLE
   always_comb begin
      w_k     = b[SHW-1:0];
      w_steps = (w_k > K_MAX) ? K_MAX : w_k;
      w_sum   = {1'b0, a} + {1'b0, b};
      w_adc   = w_sum + {{W{1'b0}}, r_flag_c};
      // bit W of the difference is the borrow, so C = ~borrow = (a >= b)
      w_diff  = {1'b0, a} - {1'b0, b};
      w_shl1  = {a[W-2:0], 1'b0};
      w_shr1  = {1'b0, a[W-1:1]};
      // first partial product, taken on the accepting edge
      w_m0    = b[0] ? {1'b0, a} : '0;
      w_fin   = 1'b1;
      w_ill   = 1'b0;
      w_wr    = 1'b1;
      w_go_sh = 1'b0;
      w_res   = '0;
      w_c     = 1'b0;
      case (op)
         OP_ADD: begin w_res = w_sum[W-1:0];  w_c = w_sum[W];   end
         OP_ADC: begin w_res = w_adc[W-1:0];  w_c = w_adc[W];   end
         OP_SUB: begin w_res = w_diff[W-1:0]; w_c = ~w_diff[W]; end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_NOT: w_res = ~a;
         OP_MOV: w_res = a;
         OP_CMP: begin w_wr = 1'b0; w_c = ~w_diff[W]; end
         OP_SHL, OP_SHR: begin
            if (w_steps == '0) begin
               w_res = a;
            end else if (w_steps == K_ONE) begin
               w_res = (op == OP_SHR) ? w_shr1 : w_shl1;
               w_c   = (op == OP_SHR) ? a[0] : a[W-1];
            end else begin
               w_fin   = 1'b0;
               w_go_sh = 1'b1;
            end
         end
         OP_MUL: w_fin = 1'b0;
         default: begin w_ill = 1'b1; w_wr = 1'b0; end
      endcase
      w_src = w_wr ? w_res : w_diff[W-1:0];
   end

   // One iteration of the shifter and of the shift-add multiplier
   always_comb begin
      w_sh_nxt = r_dir ? {1'b0, r_acc[W-1:1]} : {r_acc[W-2:0], 1'b0};
      w_sh_out = r_dir ? r_acc[0] : r_acc[W-1];
      w_madd   = {1'b0, r_phi} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      w_mhi    = w_madd[W:1];
      w_mlo    = {w_madd[0], r_acc[W-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_dir     <= 1'b0;
         r_acc     <= '0;
         r_phi     <= '0;
         r_mcand   <= '0;
         r_rslt    <= '0;
         r_rslt_hi <= '0;
         r_flag_c  <= 1'b0;
         r_flag_z  <= 1'b0;
         r_flag_p  <= 1'b0;
         r_flag_n  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_fin) begin
                     r_done <= 1'b1;
                     r_err  <= w_ill;
                     // illegal opcodes leave results and flags untouched
                     if (!w_ill) begin
                        if (w_wr) r_rslt <= w_res;
                        r_rslt_hi <= '0;
                        r_flag_c  <= w_c;
                        {r_flag_z, r_flag_p, r_flag_n} <= f_zpn(w_src);
                     end
                  end else if (w_go_sh) begin
                     // first bit moves on the accepting edge
                     r_state <= S_SHIFT;
                     r_busy  <= 1'b1;
                     r_dir   <= (op == OP_SHR);
                     r_acc   <= (op == OP_SHR) ? w_shr1 : w_shl1;
                     r_cnt   <= w_steps - K_ONE;
                  end else begin
                     // r_phi:r_acc is the running {hi,lo}; r_acc starts as b
                     r_state <= S_MUL;
                     r_busy  <= 1'b1;
                     r_mcand <= a;
                     r_phi   <= w_m0[W:1];
                     r_acc   <= {w_m0[0], b[W-1:1]};
                     r_cnt   <= SHW'(W - 1);
                  end
               end
            end
            S_SHIFT: begin
               if (r_cnt == K_ONE) begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_rslt    <= w_sh_nxt;
                  r_rslt_hi <= '0;
                  r_flag_c  <= w_sh_out;
                  {r_flag_z, r_flag_p, r_flag_n} <= f_zpn(w_sh_nxt);
               end else begin
                  r_acc <= w_sh_nxt;
                  r_cnt <= r_cnt - K_ONE;
               end
            end
            S_MUL: begin
               if (r_cnt == K_ONE) begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_rslt    <= w_mlo;
                  r_rslt_hi <= w_mhi;
                  r_flag_c  <= (w_mhi != '0);
                  {r_flag_z, r_flag_p, r_flag_n} <= f_zpn(w_mlo);
               end else begin
                  r_phi <= w_mhi;
                  r_acc <= w_mlo;
                  r_cnt <= r_cnt - K_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rslt    = r_rslt;
   assign rslt_hi = r_rslt_hi;
   assign flag_c  = r_flag_c;
   assign flag_z  = r_flag_z;
   assign flag_p  = r_flag_p;
   assign flag_n  = r_flag_n;
   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc.
// A cycle-level behavioural model (plain arithmetic on the latched operands plus
// a latency countdown) is compared against every DUT output on every clock.
// Directed sequences pin the model with hand-computed values, then a randomized
// phase issues back-to-back and overlapping requests with occasional resets.
// -----------------------------------------------------------------------------
module tb_alu_mc;
   localparam int W   = 8;
   localparam int OPW = 4;
   localparam int SHW = $clog2(W) + 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [OPW-1:0] op = '0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [W-1:0]   rslt;
   logic [W-1:0]   rslt_hi;
   logic           flag_c, flag_z, flag_p, flag_n, busy, done, err;

   alu_mc #(.W(W), .OPW(OPW), .SHW(SHW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .rslt(rslt), .rslt_hi(rslt_hi), .flag_c(flag_c), .flag_z(flag_z),
      .flag_p(flag_p), .flag_n(flag_n), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_r, m_hi, m_c, m_z, m_p, m_n;
   int     m_rem;
   longint p_r, p_hi, p_c, p_src;
   bit     p_ill, p_wr;

   task automatic model_issue(input int o, input longint A, input longint B);
      longint mask;
      longint s;
      int k, n, lat;
      mask  = (64'd1 << W) - 1;
      p_ill = 0; p_wr = 1; p_hi = 0; p_c = 0; p_r = 0; lat = 1;
      case (o)
         0: begin s = A + B;       p_r = s & mask; p_c = (s >> W) & 1; end
         1: begin s = A + B + m_c; p_r = s & mask; p_c = (s >> W) & 1; end
         2: begin p_r = (A - B) & mask; p_c = (A >= B); end
         3: p_r = A & B;
         4: p_r = A | B;
         5: p_r = A ^ B;
         6: p_r = (~A) & mask;
         7: p_r = A;
         8: begin p_wr = 0; p_src = (A - B) & mask; p_c = (A >= B); end
         9, 10: begin
            k = int'(B % (64'd1 << SHW));
            n = (k > W) ? W : k;
            lat = (n < 1) ? 1 : n;
            if (n == 0) begin
               p_r = A;
            end else if (o == 9) begin
               s = A << n; p_r = s & mask; p_c = (s >> W) & 1;
            end else begin
               p_r = A >> n; p_c = (A >> (n - 1)) & 1;
            end
         end
         11: begin s = A * B; p_r = s & mask; p_hi = s >> W; p_c = (p_hi != 0); lat = W; end
         default: begin p_ill = 1; p_wr = 0; end
      endcase
      if (p_wr) p_src = p_r;
      m_rem = lat;
   endtask

   // ---------------- per-cycle compare ----------------
   logic           s_start;
   logic [OPW-1:0] s_op;
   logic [W-1:0]   s_a, s_b;
   bit             exp_done, exp_err;

   initial begin
      m_r = 0; m_hi = 0; m_c = 0; m_z = 0; m_p = 0; m_n = 0; m_rem = 0;
      forever begin
         @(posedge clk);
         s_start = start; s_op = op; s_a = a; s_b = b;
         #1;
         exp_done = 0; exp_err = 0;
         if (!rst_n) begin
            m_r = 0; m_hi = 0; m_c = 0; m_z = 0; m_p = 0; m_n = 0; m_rem = 0;
         end else begin
            if (m_rem == 0 && s_start) model_issue(int'(s_op), longint'(s_a), longint'(s_b));
            if (m_rem > 0) begin
               m_rem--;
               if (m_rem == 0) begin
                  exp_done = 1;
                  exp_err  = p_ill;
                  if (!p_ill) begin
                     if (p_wr) m_r = p_r;
                     m_hi = p_hi;
                     m_c  = p_c;
                     m_z  = (p_src == 0);
                     m_p  = $countones(p_src) & 1;
                     m_n  = (p_src >> (W - 1)) & 1;
                  end
               end
            end
         end
         chk("done",    64'(done),    64'(exp_done));
         chk("busy",    64'(busy),    64'(m_rem > 0));
         chk("err",     64'(err),     64'(exp_err));
         chk("rslt",    64'(rslt),    m_r);
         chk("rslt_hi", 64'(rslt_hi), m_hi);
         chk("flag_c",  64'(flag_c),  m_c);
         chk("flag_z",  64'(flag_z),  m_z);
         chk("flag_p",  64'(flag_p),  m_p);
         chk("flag_n",  64'(flag_n),  m_n);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic issue(input int o, input int av, input int bv);
      @(negedge clk);
      start = 1'b1; op = OPW'(o); a = W'(av); b = W'(bv);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end while (!done && n < 40);
      if (!done) chk("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic chk_flags(input string t, input int c, input int z, input int p, input int n);
      chk({t, "_C"}, 64'(flag_c), 64'(c));
      chk({t, "_Z"}, 64'(flag_z), 64'(z));
      chk({t, "_P"}, 64'(flag_p), 64'(p));
      chk({t, "_N"}, 64'(flag_n), 64'(n));
   endtask

   int lat, dcnt, dat;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rslt", 64'(rslt), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk_flags("rst", 0, 0, 0, 0);
      rst_n = 1'b1;

      issue(0, 'hF0, 'h20); wait_done(lat);
      chk("add_lat", 64'(lat), 64'd1);
      chk("add_r", 64'(rslt), 64'h10); chk_flags("add", 1, 0, 1, 0);
      issue(1, 'h01, 'h01); wait_done(lat);
      chk("adc_r", 64'(rslt), 64'h03); chk("adc_C", 64'(flag_c), 64'd0);

      issue(2, 'h05, 'h05); wait_done(lat);
      chk("sub_r", 64'(rslt), 64'h00); chk_flags("sub", 1, 1, 0, 0);
      issue(8, 'h03, 'h07); wait_done(lat);
      chk("cmp_r", 64'(rslt), 64'h00); chk_flags("cmp", 0, 0, 0, 1);

      issue(9, 'h81, 3); wait_done(lat);
      chk("shl3_lat", 64'(lat), 64'd3);
      chk("shl3_r", 64'(rslt), 64'h08); chk("shl3_C", 64'(flag_c), 64'd0);
      issue(10, 'h81, 1); wait_done(lat);
      chk("shr1_lat", 64'(lat), 64'd1);
      chk("shr1_r", 64'(rslt), 64'h40); chk("shr1_C", 64'(flag_c), 64'd1);
      issue(10, 'h81, 9); wait_done(lat);
      chk("shr9_lat", 64'(lat), 64'd8);
      chk("shr9_r", 64'(rslt), 64'h00); chk("shr9_C", 64'(flag_c), 64'd1);
      issue(9, 'h81, 0); wait_done(lat);
      chk("shl0_lat", 64'(lat), 64'd1);
      chk("shl0_r", 64'(rslt), 64'h81); chk("shl0_C", 64'(flag_c), 64'd0);

      // MUL with a start pulse that must be ignored while busy
      issue(11, 'hFF, 'hFF);
      dcnt = 0; dat = 0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start = (n == 3);
         if (n == 3) begin op = '0; a = 8'h01; b = 8'h01; end
         if (done) begin dcnt++; dat = n; end
      end
      chk("mul_dones", 64'(dcnt), 64'd1);
      chk("mul_lat", 64'(dat), 64'd8);
      chk("mul_lo", 64'(rslt), 64'h01); chk("mul_hi", 64'(rslt_hi), 64'hFE);
      chk("mul_C", 64'(flag_c), 64'd1);

      // reset in the middle of a MUL
      issue(11, 'h12, 'h34);
      for (int n = 1; n <= 4; n++) begin @(negedge clk); start = 1'b0; end
      rst_n = 1'b0;
      #1;
      chk("rmid_rslt", 64'(rslt), 64'h0); chk("rmid_hi", 64'(rslt_hi), 64'h0);
      chk("rmid_busy", 64'(busy), 64'h0); chk("rmid_done", 64'(done), 64'h0);
      chk_flags("rmid", 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;
      dcnt = 0;
      repeat (12) begin @(negedge clk); if (done) dcnt++; end
      chk("rmid_nodone", 64'(dcnt), 64'd0);
      issue(0, 'h02, 'h03); wait_done(lat);
      chk("radd_r", 64'(rslt), 64'h05);
      @(negedge clk); chk("radd_pulse", 64'(done), 64'd0);

      // illegal opcode leaves results alone, then NOT
      issue(0, 'hF0, 'h20); wait_done(lat);
      issue(15, 'h55, 'hAA); wait_done(lat);
      chk("ill_err", 64'(err), 64'd1); chk("ill_r", 64'(rslt), 64'h10);
      chk_flags("ill", 1, 0, 1, 0);
      issue(6, 'h0F, 'h00); wait_done(lat);
      chk("not_r", 64'(rslt), 64'hF0); chk("not_err", 64'(err), 64'd0);
      chk("not_N", 64'(flag_n), 64'd1); chk("not_C", 64'(flag_c), 64'd0);

      // randomized traffic; the compare process checks every cycle
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0; start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         start = ($urandom_range(0, 3) != 0);
         op    = OPW'($urandom_range(0, 15));
         a     = W'($urandom);
         b     = W'($urandom);
         if ($urandom_range(0, 1) == 1) b = W'($urandom_range(0, 10));
      end
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
